// File: rtl/md_pkg.sv
// Shared definitions for the multiply/divide unit: op codes, FSM states and
// sign-conditioning helpers.
package md_pkg;

  // Operation codes; bit 0 clear means a signed operation for MULT/DIV/MADD.
  localparam logic [2:0] MD_OP_MULT  = 3'b000;
  localparam logic [2:0] MD_OP_MULTU = 3'b001;
  localparam logic [2:0] MD_OP_DIV   = 3'b010;
  localparam logic [2:0] MD_OP_DIVU  = 3'b011;
  localparam logic [2:0] MD_OP_MTHI  = 3'b100;
  localparam logic [2:0] MD_OP_MTLO  = 3'b101;
  localparam logic [2:0] MD_OP_MADD  = 3'b110;
  localparam logic [2:0] MD_OP_MADDU = 3'b111;

  // Helpers work on a fixed wide container; callers zero-extend their operand
  // in and size-cast the result back, so any WIDTH up to MD_MAX_W is served.
  localparam int MD_MAX_W = 64;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_MUL     = 2'd1,
    ST_DIV     = 2'd2,
    ST_DIV_FIX = 2'd3
  } md_state_e;

  // Two's-complement negate when en is set.
  function automatic logic [MD_MAX_W-1:0] neg_w(input logic [MD_MAX_W-1:0] v,
                                                input logic en);
    return en ? (~v + MD_MAX_W'(1)) : v;
  endfunction

  // Magnitude of a value whose sign bit (as seen at its true width) is is_neg.
  // The most negative value maps onto its unsigned magnitude.
  function automatic logic [MD_MAX_W-1:0] abs_w(input logic [MD_MAX_W-1:0] v,
                                                input logic is_neg);
    return neg_w(v, is_neg);
  endfunction

endpackage

// File: rtl/md_divider_iter.sv
// Unsigned restoring divider, one quotient bit per clock, WIDTH iterations.
// A zero divisor naturally yields quotient = all ones, remainder = dividend.
module md_divider_iter
  import md_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic             cancel_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic             done_o,
  output logic [WIDTH-1:0] quotient_o,
  output logic [WIDTH-1:0] remainder_o
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] dsr_q, dsr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             active_q, active_d;
  logic [WIDTH:0]   rem_shift;
  logic [WIDTH:0]   diff;

  // done_o is high in the cycle whose closing edge performs the final
  // iteration, so the results are settled right after that edge.
  assign done_o      = active_q && (cnt_q == CNT_W'(1));
  assign quotient_o  = quo_q;
  assign remainder_o = rem_q;

  // Iteration step: shift in next dividend bit, trial-subtract, restore on borrow.
  always_comb begin
    quo_d     = quo_q;
    rem_d     = rem_q;
    dsr_d     = dsr_q;
    cnt_d     = cnt_q;
    active_d  = active_q;
    rem_shift = {rem_q, quo_q[WIDTH-1]};
    diff      = rem_shift - {1'b0, dsr_q};
    if (cancel_i) begin
      active_d = 1'b0;
      cnt_d    = '0;
    end else if (start_i) begin
      quo_d    = dividend_i;
      rem_d    = '0;
      dsr_d    = divisor_i;
      cnt_d    = CNT_W'(WIDTH);
      active_d = 1'b1;
    end else if (active_q) begin
      if (!diff[WIDTH]) begin
        rem_d = diff[WIDTH-1:0];
        quo_d = {quo_q[WIDTH-2:0], 1'b1};
      end else begin
        rem_d = rem_shift[WIDTH-1:0];
        quo_d = {quo_q[WIDTH-2:0], 1'b0};
      end
      cnt_d = cnt_q - CNT_W'(1);
      if (cnt_q == CNT_W'(1)) active_d = 1'b0;
    end
  end

  // Divider state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      quo_q    <= '0;
      rem_q    <= '0;
      dsr_q    <= '0;
      cnt_q    <= '0;
      active_q <= 1'b0;
    end else begin
      quo_q    <= quo_d;
      rem_q    <= rem_d;
      dsr_q    <= dsr_d;
      cnt_q    <= cnt_d;
      active_q <= active_d;
    end
  end

endmodule

// File: rtl/md_unit_seq.sv
// Multi-cycle multiply/divide unit with HI/LO registers for the EX stage.
// Multiplies complete MUL_LAT cycles after acceptance; divides take WIDTH
// iterations plus one sign-fix cycle. cancel aborts without touching HI/LO.
module md_unit_seq
  import md_pkg::*;
#(
  parameter int WIDTH   = 32,  // even, >= 8, <= MD_MAX_W
  parameter int MUL_LAT = 4    // >= 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cancel,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_W = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;

  md_state_e          state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
  logic               mul_signed_q, mul_signed_d;
  logic               mul_acc_q, mul_acc_d;
  logic               quo_neg_q, quo_neg_d;
  logic               rem_neg_q, rem_neg_d;

  logic               a_neg, b_neg;
  logic               div_start, div_done;
  logic [WIDTH-1:0]   div_dividend, div_divisor, div_quo, div_rem;
  logic [2*WIDTH-1:0] a_ext, b_ext, prod, acc;

  assign busy = (state_q != ST_IDLE);
  assign hi   = hi_q;
  assign lo   = lo_q;

  // Signed divides feed magnitudes to the unsigned core; signs are applied later.
  assign a_neg        = ~op[0] & a[WIDTH-1];
  assign b_neg        = ~op[0] & b[WIDTH-1];
  assign div_dividend = WIDTH'(abs_w(MD_MAX_W'(a), a_neg));
  assign div_divisor  = WIDTH'(abs_w(MD_MAX_W'(b), b_neg));

  // Full-width product from latched operands, sign- or zero-extended.
  assign a_ext = {{WIDTH{mul_signed_q & a_q[WIDTH-1]}}, a_q};
  assign b_ext = {{WIDTH{mul_signed_q & b_q[WIDTH-1]}}, b_q};
  assign prod  = a_ext * b_ext;
  assign acc   = {hi_q, lo_q} + prod;

  md_divider_iter #(.WIDTH(WIDTH)) u_div (
    .clk        (clk),
    .rst_n      (rst_n),
    .start_i    (div_start),
    .cancel_i   (cancel),
    .dividend_i (div_dividend),
    .divisor_i  (div_divisor),
    .done_o     (div_done),
    .quotient_o (div_quo),
    .remainder_o(div_rem)
  );

  // Next-state, operand latching and HI/LO update decisions.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    hi_d         = hi_q;
    lo_d         = lo_q;
    a_d          = a_q;
    b_d          = b_q;
    mul_signed_d = mul_signed_q;
    mul_acc_d    = mul_acc_q;
    quo_neg_d    = quo_neg_q;
    rem_neg_d    = rem_neg_q;
    div_start    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start && !cancel) begin
          case (op)
            MD_OP_MTHI: hi_d = a;
            MD_OP_MTLO: lo_d = a;
            MD_OP_DIV, MD_OP_DIVU: begin
              div_start = 1'b1;
              quo_neg_d = a_neg ^ b_neg;
              rem_neg_d = a_neg;
              state_d   = ST_DIV;
            end
            default: begin
              a_d          = a;
              b_d          = b;
              mul_signed_d = ~op[0];
              mul_acc_d    = op[2];
              cnt_d        = CNT_W'(MUL_LAT - 1);
              state_d      = ST_MUL;
            end
          endcase
        end
      end
      ST_MUL: begin
        if (cancel) begin
          state_d = ST_IDLE;
        end else if (cnt_q == '0) begin
          {hi_d, lo_d} = mul_acc_q ? acc : prod;
          state_d      = ST_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_DIV: begin
        if (cancel) state_d = ST_IDLE;
        else if (div_done) state_d = ST_DIV_FIX;
      end
      ST_DIV_FIX: begin
        if (!cancel) begin
          lo_d = WIDTH'(neg_w(MD_MAX_W'(div_quo), quo_neg_q));
          hi_d = WIDTH'(neg_w(MD_MAX_W'(div_rem), rem_neg_q));
        end
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Architectural and control registers; reset clears HI/LO immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      hi_q         <= '0;
      lo_q         <= '0;
      a_q          <= '0;
      b_q          <= '0;
      mul_signed_q <= 1'b0;
      mul_acc_q    <= 1'b0;
      quo_neg_q    <= 1'b0;
      rem_neg_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      hi_q         <= hi_d;
      lo_q         <= lo_d;
      a_q          <= a_d;
      b_q          <= b_d;
      mul_signed_q <= mul_signed_d;
      mul_acc_q    <= mul_acc_d;
      quo_neg_q    <= quo_neg_d;
      rem_neg_q    <= rem_neg_d;
    end
  end

endmodule

// File: doc/md_unit_seq.md
Name: md_unit_seq

Overview:
- Multi-cycle, parametrised multiply/divide unit with architectural HI/LO registers for the MIPS pipeline EX stage.
- Supports signed and unsigned multiply, multiply-accumulate, divide, and MTHI/MTLO.
- Exposes a start/busy handshake; hazard logic stalls MFHI/MFLO and new MD ops while busy=1.
- A cancel input aborts an in-flight op on a pipeline flush or exception.

Parameters:
- WIDTH, 32, operand and HI/LO width; must be even and at least 8.
- MUL_LAT, 4, cycles from accepted multiply/MADD to HI/LO update; must be at least 1.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  request to launch op; sampled only when busy=0
- op  in  3  operation code, encoding below
- a  in  WIDTH  operand A (rs); also source for MTHI/MTLO
- b  in  WIDTH  operand B (rt)
- cancel  in  1  abort in-flight op, same priority as flush
- busy  out  1  unit occupied; HI/LO not yet final
- hi  out  WIDTH  HI register
- lo  out  WIDTH  LO register

Behaviour:
- Op encoding (MD_OP_*):
  - 000 MULT, 001 MULTU
  - 010 DIV, 011 DIVU
  - 100 MTHI, 101 MTLO
  - 110 MADD, 111 MADDU
- Reset: rst_n=0 forces state=IDLE and busy=0, hi=0, lo=0 immediately, regardless of any op in flight.
- States: IDLE, MUL, DIV, DIV_FIX.
- Accept: start=1 in IDLE at edge T. a, b and op are latched; the unit does not re-read them afterwards.
- start while busy=1 is ignored, with no side effects.
- MTHI/MTLO:
  - Single cycle; no state change; busy stays 0.
  - hi (or lo) = a at edge T.
- MUL, MADD, MADDU:
  - Go to MUL and load the latency counter with MUL_LAT-1. busy=1 from T.
  - Product is 2*WIDTH bits. Signed ops sign-extend, unsigned ops zero-extend.
  - At edge T+MUL_LAT: {hi,lo} = product for MULT/MULTU, or {hi,lo} + product for MADD/MADDU.
  - The accumulate uses {hi,lo} as sampled at that edge, modulo 2^(2*WIDTH); there is no overflow flag.
  - At the same edge busy falls to 0 and state returns to IDLE.
- DIV, DIVU:
  - Unsigned restoring divider on magnitudes: WIDTH iterations in DIV, one per cycle, then one DIV_FIX cycle.
  - DIV_FIX applies signs: quotient negated if the operand signs differ; remainder takes the sign of a.
  - lo = quotient, hi = remainder, written at edge T+WIDTH+1, together with busy falling.
- Divide by zero (b=0): full latency is still spent. Result is lo = all ones (unsigned) or -1/+1 by the sign rule (signed); hi = a. The bench checks these values exactly.
- Signed overflow (a = MIN, b = -1): lo = MIN, hi = 0.
- cancel=1 while busy:
  - At the next edge, state goes to IDLE, busy goes to 0, and hi/lo keep their pre-op values.
  - A concurrent start on that edge is ignored.
- cancel=1 in IDLE has no effect, but it suppresses start on the same cycle.
- hi/lo change only on an MTHI/MTLO edge, an op-completion edge, or reset.

Decomposition:
- Shared package md_pkg:
  - MD_OP_* localparams
  - State encoding
  - Helper functions abs_w and neg_w
- One sub-module, md_divider_iter: the restoring divider core with start, done, unsigned dividend/divisor, quotient and remainder.
  - The top level handles sign conditioning, the multiplier pipeline/counter, HI/LO registers, and cancel.

Test Plan:
All cases use WIDTH=32 and MUL_LAT=4.
1. MULT a=0xFFFFFFFD, b=7 -> busy high for exactly 4 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFEB. MULTU a=0xFFFFFFFF, b=2 -> hi=1, lo=0xFFFFFFFE.
2. DIV a=-7, b=2 -> after 33 busy cycles, lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU a=7, b=2 -> lo=3, hi=1.
3. DIVU a=5, b=0 -> lo=0xFFFFFFFF, hi=5. DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0.
4. MTLO a=0xFFFFFFFF, MTHI a=0, then MADDU a=1, b=1 -> hi=1, lo=0. MADD a=-1, b=1 from hi=0, lo=0 -> hi=lo=0xFFFFFFFF.
5. Start DIV, assert cancel on busy cycle 10 -> busy=0 next cycle; hi/lo unchanged. Start pulses during a MUL are ignored, and the result matches the first op only.
6. rst_n low mid-MUL (cycle 2) -> hi=lo=0 and busy=0 asynchronously. After release, a new MULT 3*5 gives lo=15, hi=0.
